// File: rtl/vip_matrix_gen_3x3_param_pkg.sv
// Shared constants for the vip 3x3 window generator family.
package vip_matrix_gen_3x3_param_pkg;

  localparam int BORDER_ZERO = 0;  // missing taps read as 0
  localparam int BORDER_REPL = 1;  // missing taps copy the nearest valid pixel
  localparam int ROW_W       = 12; // row counter width, saturates at all-ones

  // Column counter must hold 0..MAX_W so an over-long line is detectable.
  function automatic int col_w(input int max_w);
    return $clog2(max_w + 1);
  endfunction

endpackage

// File: rtl/vip_line_buffer_2x.sv
// Two cascaded line RAMs: dout0 = previous line, dout1 = line before that.
// A write shifts the old lb0 word into lb1 at the same address.
module vip_line_buffer_2x #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(MAX_W)-1:0]   addr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout0,
  output logic [DATA_W-1:0]          dout1
);

  logic [DATA_W-1:0] mem0 [MAX_W];
  logic [DATA_W-1:0] mem1 [MAX_W];

  // Read-before-write on both RAMs; lb1 captures lb0's old word.
  always_ff @(posedge clk) begin
    dout0 <= mem0[addr];
    dout1 <= mem1[addr];
    if (we) begin
      mem0[addr] <= din;
      mem1[addr] <= mem0[addr];
    end
  end

endmodule

// File: rtl/vip_matrix_gen_3x3_param.sv
// 3x3 neighbourhood generator over a raster stream, 2-clock latency.
// MAX_W must be at least 4.
module vip_matrix_gen_3x3_param
  import vip_matrix_gen_3x3_param_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MAX_W       = 1024,
  parameter int BORDER_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_data,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic [DATA_W-1:0] matrix_p11, matrix_p12, matrix_p13,
  output logic [DATA_W-1:0] matrix_p21, matrix_p22, matrix_p23,
  output logic [DATA_W-1:0] matrix_p31, matrix_p32, matrix_p33,
  output logic              matrix_full,
  output logic              line_overflow
);

  localparam int COL_W = col_w(MAX_W);
  localparam int AW    = $clog2(MAX_W);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_W);
  localparam bit REPL = (BORDER_MODE == BORDER_REPL);

  // win[r][c]: r=0 oldest line, c=0 oldest pixel
  typedef logic [2:0][2:0][DATA_W-1:0] win_t;

  logic              acc, in_range;
  logic [DATA_W-1:0] lb_dout0, lb_dout1;

  logic              vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] s1_pix_q, s1_pix_d;
  logic [COL_W-1:0]  s1_col_q, s1_col_d;
  logic [ROW_W-1:0]  s1_row_q, s1_row_d;
  logic              s1_acc_q, s1_acc_d, s1_hr_q, s1_hr_d, s1_vs_q, s1_vs_d;
  logic              o_vs_q, o_vs_d, o_hr_q, o_hr_d, o_ck_q, o_ck_d;
  logic              full_q, full_d;
  win_t              win_q, win_d, shf;
  logic [2:0][DATA_W-1:0] ncol;

  assign acc      = per_frame_href & per_frame_clken;
  assign in_range = (col_q < COL_MAX);

  vip_line_buffer_2x #(.DATA_W(DATA_W), .MAX_W(MAX_W)) u_lb (
    .clk   (clk),
    .we    (acc & in_range),
    .addr  (col_q[AW-1:0]),
    .din   (per_img_data),
    .dout0 (lb_dout0),
    .dout1 (lb_dout1)
  );

  // Position counters, edge detect, overflow flag and stage-1 capture.
  always_comb begin
    vs_prev_d = per_frame_vsync;
    hr_prev_d = per_frame_href;
    col_d     = col_q;
    row_d     = row_q;
    ovf_d     = ovf_q;
    if (acc) begin
      // col parks at MAX_W once the line overruns the RAM
      if (in_range) col_d = col_q + COL_W'(1);
      else          ovf_d = 1'b1;
    end
    if (hr_prev_q && !per_frame_href) begin
      col_d = '0;
      if (row_q != '1) row_d = row_q + ROW_W'(1);
    end
    // frame start overrides a coincident line end
    if (per_frame_vsync && !vs_prev_q) begin
      col_d = '0;
      row_d = '0;
      ovf_d = 1'b0;
    end
    s1_pix_d = per_img_data;
    s1_col_d = col_q;
    s1_row_d = row_q;
    s1_acc_d = acc;
    s1_hr_d  = per_frame_href;
    s1_vs_d  = per_frame_vsync;
    o_vs_d   = s1_vs_q;
    o_hr_d   = s1_hr_q;
    o_ck_d   = s1_acc_q;
  end

  // Stage 2: row fill of the incoming column, then shift with column fill.
  always_comb begin
    ncol[0] = lb_dout1;
    ncol[1] = lb_dout0;
    ncol[2] = s1_pix_q;
    if (s1_row_q == '0 || s1_col_q >= COL_MAX) begin
      ncol[0] = REPL ? s1_pix_q : '0;
      ncol[1] = REPL ? s1_pix_q : '0;
    end else if (s1_row_q == ROW_W'(1)) begin
      ncol[0] = REPL ? lb_dout0 : '0;
    end
    for (int r = 0; r < 3; r++) begin
      shf[r][0] = win_q[r][1];
      shf[r][1] = win_q[r][2];
      shf[r][2] = ncol[r];
      if (s1_col_q == '0) begin
        shf[r][0] = REPL ? ncol[r] : '0;
        shf[r][1] = REPL ? ncol[r] : '0;
      end else if (s1_col_q == COL_W'(1)) begin
        shf[r][0] = REPL ? shf[r][1] : '0;
      end
    end
    win_d = '0;
    if (s1_hr_q) win_d = s1_acc_q ? shf : win_q;
    full_d = s1_acc_q && (s1_row_q >= ROW_W'(2)) &&
             (s1_col_q >= COL_W'(2)) && (s1_col_q < COL_MAX);
  end

  // All state registers; line RAM contents are not reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q <= 1'b0; hr_prev_q <= 1'b0;
      col_q     <= '0;   row_q     <= '0;   ovf_q <= 1'b0;
      s1_pix_q  <= '0;   s1_col_q  <= '0;   s1_row_q <= '0;
      s1_acc_q  <= 1'b0; s1_hr_q   <= 1'b0; s1_vs_q  <= 1'b0;
      o_vs_q    <= 1'b0; o_hr_q    <= 1'b0; o_ck_q   <= 1'b0;
      full_q    <= 1'b0; win_q     <= '0;
    end else begin
      vs_prev_q <= vs_prev_d; hr_prev_q <= hr_prev_d;
      col_q     <= col_d;     row_q     <= row_d;     ovf_q <= ovf_d;
      s1_pix_q  <= s1_pix_d;  s1_col_q  <= s1_col_d;  s1_row_q <= s1_row_d;
      s1_acc_q  <= s1_acc_d;  s1_hr_q   <= s1_hr_d;   s1_vs_q  <= s1_vs_d;
      o_vs_q    <= o_vs_d;    o_hr_q    <= o_hr_d;    o_ck_q   <= o_ck_d;
      full_q    <= full_d;    win_q     <= win_d;
    end
  end

  assign matrix_frame_vsync = o_vs_q;
  assign matrix_frame_href  = o_hr_q;
  assign matrix_frame_clken = o_ck_q;
  assign matrix_full        = full_q;
  assign line_overflow      = ovf_q;
  assign matrix_p11 = win_q[0][0];
  assign matrix_p12 = win_q[0][1];
  assign matrix_p13 = win_q[0][2];
  assign matrix_p21 = win_q[1][0];
  assign matrix_p22 = win_q[1][1];
  assign matrix_p23 = win_q[1][2];
  assign matrix_p31 = win_q[2][0];
  assign matrix_p32 = win_q[2][1];
  assign matrix_p33 = win_q[2][2];

endmodule

// File: tb/tb_vip_matrix_gen_3x3_param.sv
// Directed bench: three DUTs share one stimulus stream.
//   0: MAX_W=8 zero border, 1: MAX_W=8 replicate border, 2: MAX_W=4 zero border.
module tb_vip_matrix_gen_3x3_param;

  logic clk, rst;
  logic vsync, href, clken;
  logic [7:0] din;

  logic [2:0] o_vs, o_hr, o_ck, o_full, o_ovf;
  logic [8:0][7:0] o_p [3];  // {p11,p12,p13,p21,p22,p23,p31,p32,p33}

  int total = 0;
  int bad   = 0;

  bit mon_en = 0;
  logic [72:0] qz[$], qr[$], qs[$];  // {taps, full} per output strobe

  vip_matrix_gen_3x3_param #(.DATA_W(8), .MAX_W(8), .BORDER_MODE(0)) u_z (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_data(din),
    .matrix_frame_vsync(o_vs[0]), .matrix_frame_href(o_hr[0]), .matrix_frame_clken(o_ck[0]),
    .matrix_p11(o_p[0][8]), .matrix_p12(o_p[0][7]), .matrix_p13(o_p[0][6]),
    .matrix_p21(o_p[0][5]), .matrix_p22(o_p[0][4]), .matrix_p23(o_p[0][3]),
    .matrix_p31(o_p[0][2]), .matrix_p32(o_p[0][1]), .matrix_p33(o_p[0][0]),
    .matrix_full(o_full[0]), .line_overflow(o_ovf[0]));

  vip_matrix_gen_3x3_param #(.DATA_W(8), .MAX_W(8), .BORDER_MODE(1)) u_r (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_data(din),
    .matrix_frame_vsync(o_vs[1]), .matrix_frame_href(o_hr[1]), .matrix_frame_clken(o_ck[1]),
    .matrix_p11(o_p[1][8]), .matrix_p12(o_p[1][7]), .matrix_p13(o_p[1][6]),
    .matrix_p21(o_p[1][5]), .matrix_p22(o_p[1][4]), .matrix_p23(o_p[1][3]),
    .matrix_p31(o_p[1][2]), .matrix_p32(o_p[1][1]), .matrix_p33(o_p[1][0]),
    .matrix_full(o_full[1]), .line_overflow(o_ovf[1]));

  vip_matrix_gen_3x3_param #(.DATA_W(8), .MAX_W(4), .BORDER_MODE(0)) u_s (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_data(din),
    .matrix_frame_vsync(o_vs[2]), .matrix_frame_href(o_hr[2]), .matrix_frame_clken(o_ck[2]),
    .matrix_p11(o_p[2][8]), .matrix_p12(o_p[2][7]), .matrix_p13(o_p[2][6]),
    .matrix_p21(o_p[2][5]), .matrix_p22(o_p[2][4]), .matrix_p23(o_p[2][3]),
    .matrix_p31(o_p[2][2]), .matrix_p32(o_p[2][1]), .matrix_p33(o_p[2][0]),
    .matrix_full(o_full[2]), .line_overflow(o_ovf[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // capture every output strobe for later indexed checks
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_ck[0]) qz.push_back({o_p[0], o_full[0]});
      if (o_ck[1]) qr.push_back({o_p[1], o_full[1]});
      if (o_ck[2]) qs.push_back({o_p[2], o_full[2]});
    end
  end

  task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // present inputs, then let the sampling edge pass; returns 1 time unit after it
  task automatic cyc(input logic v, input logic h, input logic c, input logic [7:0] d);
    vsync = v; href = h; clken = c; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
  endtask

  task automatic line(input int r, input int w);
    for (int c = 0; c < w; c++) cyc(1'b0, 1'b1, 1'b1, 8'(r * 16 + c));
    idle(3);
  endtask

  function automatic logic [72:0] qget(input int which, input int k);
    if (which == 0) return (qz.size() > k) ? qz[k] : 73'bx;
    if (which == 1) return (qr.size() > k) ? qr[k] : 73'bx;
    return (qs.size() > k) ? qs[k] : 73'bx;
  endfunction

  initial begin
    logic [7:0] fl;
    rst = 1'b1; vsync = 0; href = 0; clken = 0; din = 0;
    idle(3);
    chk("rst_taps",  {1'b0, o_p[0]}, 73'h0);
    chk("rst_flags", {68'h0, o_vs[0], o_hr[0], o_ck[0], o_full[0], o_ovf[0]}, 73'h0);
    rst = 1'b0;
    idle(2);

    // latency: strobe one edge after the sampling edge, not before
    vs_pulse();
    cyc(1'b0, 1'b1, 1'b1, 8'h55);
    chk("lat_early", {72'h0, o_ck[0]}, 73'h0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("lat_ck",    {72'h0, o_ck[0]}, 73'h1);
    chk("lat_taps",  {1'b0, o_p[0]}, {1'b0, 72'h55});
    idle(3);

    // 5x5 ramp frame
    vs_pulse();
    qz.delete(); qr.delete(); qs.delete();
    mon_en = 1;
    for (int r = 0; r < 5; r++) line(r, 5);
    mon_en = 0;
    chk("ramp_cnt", 73'(qz.size()), 73'd25);
    chk("z_r0c0",  qget(0, 0),  {72'h00_00_00_00_00_00_00_00_00, 1'b0});
    chk("z_r1c1",  qget(0, 6),  {72'h00_00_00_00_00_01_00_10_11, 1'b0});
    chk("z_r2c0",  qget(0, 10), {72'h00_00_00_00_00_10_00_00_20, 1'b0});
    chk("z_r2c2",  qget(0, 12), {72'h00_01_02_10_11_12_20_21_22, 1'b1});
    chk("z_r4c4",  qget(0, 24), {72'h22_23_24_32_33_34_42_43_44, 1'b1});
    chk("r_r0c0",  qget(1, 0),  {72'h00_00_00_00_00_00_00_00_00, 1'b0});
    chk("r_r0c1",  qget(1, 1),  {72'h00_00_01_00_00_01_00_00_01, 1'b0});
    chk("r_r1c0",  qget(1, 5),  {72'h00_00_00_00_00_00_10_10_10, 1'b0});
    chk("r_r1c2",  qget(1, 7),  {72'h00_01_02_00_01_02_10_11_12, 1'b0});
    chk("r_r2c2",  qget(1, 12), {72'h00_01_02_10_11_12_20_21_22, 1'b1});

    // clken gaps 1,0,0,1 inside href on row 0
    vs_pulse();
    cyc(1'b0, 1'b1, 1'b1, 8'hA0);
    cyc(1'b0, 1'b1, 1'b0, 8'hFF);
    chk("gap_ck0", {72'h0, o_ck[0]}, 73'h1);
    cyc(1'b0, 1'b1, 1'b0, 8'hFF);
    chk("gap_ck1", {72'h0, o_ck[0]}, 73'h0);
    cyc(1'b0, 1'b1, 1'b1, 8'hA1);
    chk("gap_ck2",   {72'h0, o_ck[0]}, 73'h0);
    chk("gap_hold",  {1'b0, o_p[0]}, {1'b0, 72'hA0});
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("gap_ck3",   {72'h0, o_ck[0]}, 73'h1);
    chk("gap_taps",  {1'b0, o_p[0]}, {1'b0, 72'hA0_A1});
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("gap_clear", {o_p[0], o_hr[0]}, 73'h0);
    idle(2);

    // MAX_W=4 instance, 6-pixel lines
    vs_pulse();
    qs.delete();
    mon_en = 1;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'(c));
      if (c == 3) chk("ovf_c3", {72'h0, o_ovf[2]}, 73'h0);
      if (c == 4) chk("ovf_c4", {72'h0, o_ovf[2]}, 73'h1);
    end
    idle(3);
    line(1, 6);
    line(2, 6);
    mon_en = 0;
    chk("s_r2c2", {72'h0, qget(2, 14) & 73'h1}, 73'h1);
    chk("s_r2c3", {72'h0, qget(2, 15) & 73'h1}, 73'h1);
    chk("s_r2c4", qget(2, 16), {72'h02_03_00_12_13_00_22_23_24, 1'b0});
    chk("s_r2c5", {72'h0, qget(2, 17) & 73'h1}, 73'h0);

    // vsync rise on the same edge as href fall
    vs_pulse();
    line(0, 5);
    line(1, 5);
    for (int c = 0; c < 5; c++) cyc(1'b0, 1'b1, 1'b1, 8'(32 + c));
    chk("ovf_pre", {72'h0, o_ovf[2]}, 73'h1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("ovf_clr", {72'h0, o_ovf[2]}, 73'h0);
    idle(2);
    qz.delete();
    mon_en = 1;
    line(0, 5);
    mon_en = 0;
    fl = '0;
    for (int k = 0; k < 5; k++) fl[k] = qget(0, k)[0];
    chk("vsh_cnt",  73'(qz.size()), 73'd5);
    chk("vsh_full", {65'h0, fl}, 73'h0);

    // reset during row 3 col 5
    vs_pulse();
    for (int r = 0; r < 3; r++) line(r, 8);
    for (int c = 0; c < 6; c++) cyc(1'b0, 1'b1, 1'b1, 8'(48 + c));
    chk("mid_pre", {70'h0, o_hr[0], o_ck[0], o_ovf[2]}, 73'h7);
    #2 rst = 1'b1;
    #1;
    chk("mid_taps",  {1'b0, o_p[0]}, 73'h0);
    chk("mid_flags", {68'h0, o_vs[0], o_hr[0], o_ck[0], o_full[0], o_ovf[2]}, 73'h0);
    idle(2);
    rst = 1'b0;
    idle(2);
    qz.delete();
    mon_en = 1;
    for (int r = 0; r < 3; r++) line(r, 8);
    mon_en = 0;
    fl = '0;
    for (int k = 0; k < 8; k++) fl[k] = qget(0, k)[0];
    chk("post_cnt",  73'(qz.size()), 73'd24);
    chk("post_row0", {65'h0, fl}, 73'h0);
    chk("post_r2c2", qget(0, 18), {72'h00_01_02_10_11_12_20_21_22, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
